// File: rtl/snappy_copy_issuer_if.sv
// rtl/snappy_copy_issuer_if.sv - copy FIFO pop port and copy-engine chunk request bundle
interface snappy_copy_issuer_if #(
  parameter int LW = 7
);
  logic          fifo_empty;
  logic [32:0]   fifo_dout;
  logic          fifo_rd_en;
  logic          cp_valid;
  logic          cp_ready;
  logic [15:0]   cp_offset;
  logic [LW-1:0] cp_len;
  logic          cp_last;
  logic          err;
  logic          done;

  // Issuer side: pops the FIFO, drives chunk requests and status flags.
  modport master (
    input  fifo_empty, fifo_dout, cp_ready,
    output fifo_rd_en, cp_valid, cp_offset, cp_len, cp_last, err, done
  );

  // Environment side: the copy FIFO plus the history-buffer copy engine.
  modport slave (
    output fifo_empty, fifo_dout, cp_ready,
    input  fifo_rd_en, cp_valid, cp_offset, cp_len, cp_last, err, done
  );
endinterface

// File: rtl/snappy_copy_issuer.sv
// rtl/snappy_copy_issuer.sv - pops copy commands and issues offset-bounded chunked back-reference requests
module snappy_copy_issuer #(
  parameter int CHUNK = 16,
  parameter int LW    = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  snappy_copy_issuer_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [15:0] CHUNK_W = 16'(CHUNK);

  logic [1:0]    state_q, state_d;
  logic [15:0]   off_q, off_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          eos_q, eos_d;
  logic          err_q, err_d;

  logic [6:0]    cmd_len;
  logic [15:0]   cmd_off;
  logic          bad_cmd;
  logic [15:0]   rem_w;
  logic [15:0]   len_w;
  logic          issuing;
  logic          fire;

  // Reserved bits [15:7] of the command word are deliberately never looked at.
  assign cmd_len = bus.fifo_dout[6:0];
  assign cmd_off = bus.fifo_dout[31:16];
  assign bad_cmd = (cmd_off == 16'd0) || (cmd_len == 7'd0) || (cmd_len > 7'd64);

  assign rem_w   = 16'(rem_q);
  assign issuing = (state_q == S_ISSUE);
  assign fire    = issuing && bus.cp_ready;

  // Chunk length: remaining bytes clipped to CHUNK and to the offset, done at
  // 16 bits so a large offset cannot alias after truncation to LW.
  always_comb begin
    len_w = rem_w;
    if (CHUNK_W < len_w) len_w = CHUNK_W;
    if (off_q < len_w)   len_w = off_q;
  end

  // Request outputs come only from state registers; they read as zero when not issuing.
  assign bus.cp_valid  = issuing;
  assign bus.cp_offset = issuing ? off_q : 16'd0;
  assign bus.cp_len    = issuing ? LW'(len_w) : '0;
  assign bus.cp_last   = issuing && eos_q && (rem_w == len_w);
  // Gated by rst_n so the pop strobe is low while reset is held even if the FIFO is not yet empty.
  assign bus.fifo_rd_en = rst_n && (state_q == S_IDLE) && !bus.fifo_empty;
  assign bus.err       = err_q;
  assign bus.done      = (state_q == S_DONE);

  // Next-state logic for the IDLE/LOAD/ISSUE/DONE command walker.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    rem_d   = rem_q;
    eos_d   = eos_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.fifo_empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        off_d = cmd_off;
        rem_d = LW'(cmd_len);
        eos_d = bus.fifo_dout[32];
        if (bad_cmd) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fire) begin
          // Offset stays put: source and destination pointers advance together.
          rem_d = rem_q - LW'(len_w);
          if (rem_w == len_w) state_d = eos_q ? S_DONE : S_IDLE;
        end
      end
      default: state_d = S_DONE;
    endcase
  end

  // State registers, cleared asynchronously so an in-flight command is abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      off_q   <= 16'd0;
      rem_q   <= '0;
      eos_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      rem_q   <= rem_d;
      eos_q   <= eos_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_snappy_copy_issuer.sv
// tb/tb_snappy_copy_issuer.sv - table-driven and scoreboard bench for snappy_copy_issuer
module tb_snappy_copy_issuer;
  localparam int CHUNK = 16;
  localparam int LW    = 7;
  localparam int NV    = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snappy_copy_issuer_if #(.LW(LW)) bus ();
  snappy_copy_issuer #(.CHUNK(CHUNK), .LW(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  typedef struct packed {
    logic [15:0] off;
    logic [6:0]  len;
    logic        last;
  } chunk_t;

  typedef struct {
    logic [15:0] off;
    logic [6:0]  len;
    logic [8:0]  rsv;
    int          exp_n;
    int          exp_first;
    logic        exp_err;
  } vec_t;

  vec_t        vt [NV];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [32:0] cmd_q [$];
  chunk_t      exp_q [$];
  chunk_t      e;
  int          hs_len [$];
  int          hs_cyc [$];
  int          rd_cnt = 0, last_cnt = 0, cyc = 0, rd_cyc = 0, fv_cyc = 0, done_cyc = 0;
  bit          want_fv = 0, pop_pend = 0, done_seen = 0, stall_p = 0;
  logic [15:0] p_off;
  logic [6:0]  p_len;
  logic        p_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Queue a command word and, if well formed, the chunks it must produce.
  task automatic push_cmd(input logic [15:0] off, input logic [6:0] len, input logic eos,
                          input logic [8:0] rsv);
    int rem;
    int c;
    cmd_q.push_back({eos, off, rsv, len});
    bus.fifo_empty = 1'b0;
    if (off != 0 && len != 0 && len <= 64) begin
      rem = int'(len);
      while (rem > 0) begin
        c = rem;
        if (c > CHUNK) c = CHUNK;
        if (c > int'(off)) c = int'(off);
        exp_q.push_back(chunk_t'{off, 7'(c), (eos && (c == rem))});
        rem -= c;
      end
    end
  endtask

  task automatic flush_env();
    cmd_q.delete();
    exp_q.delete();
    pop_pend       = 0;
    done_seen      = 0;
    bus.fifo_empty = 1'b1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Copy FIFO model: registered read data, updated on the edge that samples rd_en.
  always @(posedge clk) begin
    if (pop_pend) begin
      pop_pend = 0;
      #1;
      if (cmd_q.size() > 0) bus.fifo_dout = cmd_q.pop_front();
      bus.fifo_empty = (cmd_q.size() == 0);
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fifo_rd_en) begin
        rd_cnt++;
        rd_cyc  = cyc;
        want_fv = 1;
        pop_pend = 1;
      end
      if (stall_p) begin
        chk("stall_valid", 32'(bus.cp_valid), 32'd1);
        chk("stall_hold", {8'd0, bus.cp_offset, bus.cp_len, bus.cp_last}, {8'd0, p_off, p_len, p_last});
      end
      if (bus.cp_valid && want_fv) begin
        fv_cyc  = cyc;
        want_fv = 0;
      end
      if (bus.done && !done_seen) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      if (bus.cp_valid && bus.cp_ready) begin
        hs_len.push_back(int'(bus.cp_len));
        hs_cyc.push_back(cyc);
        if (bus.cp_last) last_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_chunk", {8'd0, bus.cp_offset, bus.cp_len, bus.cp_last}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("chunk", {8'd0, bus.cp_offset, bus.cp_len, bus.cp_last}, {8'd0, e});
        end
      end
      stall_p = bus.cp_valid && !bus.cp_ready;
      p_off   = bus.cp_offset;
      p_len   = bus.cp_len;
      p_last  = bus.cp_last;
    end else begin
      stall_p = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hs0, rd0, l0;
    vt[0] = '{16'd100,   7'd40, 9'd0,     3,  16, 1'b0};
    vt[1] = '{16'd3,     7'd10, 9'd0,     4,  3,  1'b0};
    vt[2] = '{16'd20,    7'd0,  9'd0,     0,  0,  1'b1};
    vt[3] = '{16'd8,     7'd8,  9'd0,     1,  8,  1'b1};
    vt[4] = '{16'd0,     7'd5,  9'd0,     0,  0,  1'b1};
    vt[5] = '{16'd1,     7'd64, 9'd0,     64, 1,  1'b1};
    vt[6] = '{16'd5,     7'd65, 9'd0,     0,  0,  1'b1};
    vt[7] = '{16'd65535, 7'd64, 9'd0,     4,  16, 1'b1};
    vt[8] = '{16'd16,    7'd1,  9'd0,     1,  1,  1'b1};
    vt[9] = '{16'd40,    7'd33, 9'h1FF,   3,  16, 1'b1};

    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = '0;
    bus.cp_ready   = 1'b1;
    #1;
    chk("reset_rd_en",  32'(bus.fifo_rd_en), 32'd0);
    chk("reset_valid",  32'(bus.cp_valid),   32'd0);
    chk("reset_offset", 32'(bus.cp_offset),  32'd0);
    chk("reset_len",    32'(bus.cp_len),     32'd0);
    chk("reset_last",   32'(bus.cp_last),    32'd0);
    chk("reset_err",    32'(bus.err),        32'd0);
    chk("reset_done",   32'(bus.done),       32'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);

    // Table-driven single commands with cp_ready held high.
    for (int i = 0; i < NV; i++) begin
      hs0 = hs_len.size();
      rd0 = rd_cnt;
      push_cmd(vt[i].off, vt[i].len, 1'b0, vt[i].rsv);
      for (int k = 0; k < 200 && (hs_len.size() - hs0) < vt[i].exp_n; k++) cycles(1);
      cycles(4);
      chk("vec_chunks", 32'(hs_len.size() - hs0), 32'(vt[i].exp_n));
      chk("vec_pops",   32'(rd_cnt - rd0),        32'd1);
      chk("vec_err",    32'(bus.err),             32'(vt[i].exp_err));
      if (vt[i].exp_n > 0) begin
        chk("vec_first_len", 32'(hs_len[hs0]), 32'(vt[i].exp_first));
        chk("vec_latency",   32'(fv_cyc - rd_cyc), 32'd2);
        chk("vec_b2b", 32'(hs_cyc[hs0 + vt[i].exp_n - 1] - hs_cyc[hs0]), 32'(vt[i].exp_n - 1));
      end
    end

    // Backpressure: ready pattern 1,0,0,1 repeating.
    hs0 = hs_len.size();
    rd0 = rd_cnt;
    push_cmd(16'd64, 7'd64, 1'b0, 9'd0);
    for (int k = 0; k < 64; k++) begin
      bus.cp_ready = ((k % 4) == 0) || ((k % 4) == 3);
      cycles(1);
    end
    bus.cp_ready = 1'b1;
    cycles(3);
    chk("bp_chunks", 32'(hs_len.size() - hs0), 32'd4);
    chk("bp_pops",   32'(rd_cnt - rd0),        32'd1);

    // End-of-stream run of three queued commands.
    hs0 = hs_len.size();
    rd0 = rd_cnt;
    l0  = last_cnt;
    push_cmd(16'd32, 7'd20, 1'b0, 9'd0);
    push_cmd(16'd32, 7'd1,  1'b0, 9'd0);
    push_cmd(16'd32, 7'd17, 1'b1, 9'd0);
    for (int k = 0; k < 200 && !bus.done; k++) cycles(1);
    cycles(1);
    chk("eos_done",     32'(bus.done),             32'd1);
    chk("eos_chunks",   32'(hs_len.size() - hs0),  32'd5);
    chk("eos_pops",     32'(rd_cnt - rd0),         32'd3);
    chk("eos_last_cnt", 32'(last_cnt - l0),        32'd1);
    if (hs_len.size() - hs0 == 5) begin
      chk("eos_gap",      32'(hs_cyc[hs0 + 2] - hs_cyc[hs0 + 1]), 32'd3);
      chk("eos_done_lat", 32'(done_cyc - hs_cyc[hs0 + 4]),        32'd1);
    end
    rd0 = rd_cnt;
    cmd_q.push_back({1'b0, 16'd9, 9'd0, 7'd9});
    bus.fifo_empty = 1'b0;
    cycles(5);
    chk("done_no_pop",   32'(rd_cnt - rd0), 32'd0);
    chk("done_sticky",   32'(bus.done),     32'd1);
    chk("done_no_valid", 32'(bus.cp_valid), 32'd0);

    // Asynchronous reset while in DONE with err set and FIFO non-empty.
    chk("pre_reset_err", 32'(bus.err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_done",  32'(bus.done),       32'd0);
    chk("rst_err",   32'(bus.err),        32'd0);
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    flush_env();
    cycles(2);
    rst_n = 1'b1;
    cycles(1);

    // Asynchronous reset in the middle of ISSUE, between clock edges.
    bus.cp_ready = 1'b0;
    push_cmd(16'd16, 7'd48, 1'b0, 9'd0);
    for (int k = 0; k < 10 && !bus.cp_valid; k++) cycles(1);
    chk("mid_valid_seen", 32'(bus.cp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  32'(bus.cp_valid),   32'd0);
    chk("mid_rst_offset", 32'(bus.cp_offset),  32'd0);
    chk("mid_rst_len",    32'(bus.cp_len),     32'd0);
    chk("mid_rst_rd_en",  32'(bus.fifo_rd_en), 32'd0);
    flush_env();
    cycles(2);
    rst_n = 1'b1;
    bus.cp_ready = 1'b1;
    cycles(1);

    hs0 = hs_len.size();
    rd0 = rd_cnt;
    push_cmd(16'd16, 7'd16, 1'b0, 9'd0);
    for (int k = 0; k < 20 && (hs_len.size() - hs0) < 1; k++) cycles(1);
    cycles(4);
    chk("post_rst_chunks", 32'(hs_len.size() - hs0), 32'd1);
    chk("post_rst_pops",   32'(rd_cnt - rd0),        32'd1);
    if (hs_len.size() > hs0) chk("post_rst_len", 32'(hs_len[hs0]), 32'd16);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
